// File: rtl/btb_next_pc.sv
// Fetch-stage next-PC generator: fetch PC register plus a direct-mapped BTB.
// Combines the BTB hit/target with the gshare direction to pick the next PC.
module btb_next_pc #(
    parameter int          BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ready,
    input  logic        pred_taken,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        btb_hit,
    output logic        pred_taken_out,
    output logic [31:0] pred_target
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [29:0]            r_pc_hi;
    logic                   r_pc_valid;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
    logic [29:0]            r_tgt [BTB_ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_hit;
    logic             w_take;
    logic [29:0]      w_next_hi;
    logic             w_unused;

    // PCs are word aligned; only bits [31:2] are stored and compared.
    assign w_idx     = r_pc_hi[IDX_W-1:0];
    assign w_tag     = r_pc_hi[29:IDX_W];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[31:IDX_W+2];
    assign w_unused  = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign w_hit     = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_take    = w_hit & pred_taken;
    assign w_next_hi = w_take ? r_tgt[w_idx] : r_pc_hi + 30'd1;

    assign pc             = {r_pc_hi, 2'b00};
    assign pc_valid       = r_pc_valid;
    assign btb_hit        = w_hit;
    assign pred_taken_out = w_take;
    assign pred_target    = {w_next_hi, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_hi    <= RESET_PC[31:2];
            r_pc_valid <= 1'b0;
        end else begin
            r_pc_valid <= 1'b1;
            if (redirect_valid) begin
                r_pc_hi <= redirect_pc[31:2];
            end else if (r_pc_valid && fetch_ready) begin
                r_pc_hi <= w_next_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (upd_valid && upd_taken) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Not-taken resolutions leave the entry alone; gshare tracks direction.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            r_tag[w_upd_idx] <= w_upd_tag;
            r_tgt[w_upd_idx] <= upd_target[31:2];
        end
    end
endmodule

// File: tb/tb_btb_next_pc.sv
// Table-driven bench for btb_next_pc with an expected-value queue.
// Inputs change after negedge; outputs are sampled 1ns later.
module tb_btb_next_pc;
    localparam logic [31:0] R = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pc_valid;
    logic        btb_hit;
    logic        pred_taken_out;
    logic [31:0] pred_target;

    always #5 clk = ~clk;

    btb_next_pc #(.BTB_ENTRIES(64), .RESET_PC(R)) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
        .pred_taken(pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc(pc), .pc_valid(pc_valid), .btb_hit(btb_hit),
        .pred_taken_out(pred_taken_out), .pred_target(pred_target)
    );

    typedef struct {
        logic        rst, fr, pt, rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc, utgt;
        logic        ut;
        logic        pcv;
        logic [31:0] epc;
        logic        hit, pto;
        logic [31:0] ptgt;
    } vec_t;

    typedef struct {
        int          id;
        logic        pcv;
        logic [31:0] epc;
        logic        hit, pto;
        logic [31:0] ptgt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic rs, input logic fr, input logic pt,
        input logic rv, input logic [31:0] rpc,
        input logic uv, input logic [31:0] upc,
        input logic [31:0] utgt, input logic ut,
        input logic pcv, input logic [31:0] epc,
        input logic hit, input logic pto, input logic [31:0] ptgt);
        vec_t v;
        v.rst = rs; v.fr = fr; v.pt = pt; v.rv = rv; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
        v.pcv = pcv; v.epc = epc; v.hit = hit; v.pto = pto;
        v.ptgt = ptgt;
        return v;
    endfunction

    task automatic chk32(input string nm, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int id,
                        input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %b expected %b", nm, id, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        rst = v.rst; fetch_ready = v.fr; pred_taken = v.pt;
        redirect_valid = v.rv; redirect_pc = v.rpc;
        upd_valid = v.uv; upd_pc = v.upc; upd_target = v.utgt;
        upd_taken = v.ut;
        e.id = id; e.pcv = v.pcv; e.epc = v.epc; e.hit = v.hit;
        e.pto = v.pto; e.ptgt = v.ptgt;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        chk1("pc_valid", e.id, pc_valid, e.pcv);
        chk32("pc", e.id, pc, e.epc);
        chk1("btb_hit", e.id, btb_hit, e.hit);
        chk1("pred_taken_out", e.id, pred_taken_out, e.pto);
        chk32("pred_target", e.id, pred_target, e.ptgt);
    endtask

    initial begin
        //          rs fr pt rv rpc      uv upc      utgt     ut  pcv pc      hit pto ptgt
        vecs.push_back(mk(1,1,0,0,0,       0,0,0,0,            0,R,        0,0,R+4));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            0,R,        0,0,R+4));
        vecs.push_back(mk(0,1,0,0,0,       1,R+'h10,R+'h100,1, 1,R,        0,0,R+4));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            1,R+4,      0,0,R+8));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            1,R+8,      0,0,R+'hc));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            1,R+'hc,    0,0,R+'h10));
        vecs.push_back(mk(0,1,1,0,0,       0,0,0,0,            1,R+'h10,   1,1,R+'h100));
        vecs.push_back(mk(0,1,0,1,R+'h10,  0,0,0,0,            1,R+'h100,  0,0,R+'h104));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            1,R+'h10,   1,0,R+'h14));
        vecs.push_back(mk(0,0,0,1,R+8,     0,0,0,0,            1,R+'h14,   0,0,R+'h18));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,            1,R+8,      0,0,R+'hc));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,            1,R+8,      0,0,R+'hc));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,            1,R+8,      0,0,R+'hc));
        vecs.push_back(mk(0,0,0,1,R+'h203, 0,0,0,0,            1,R+8,      0,0,R+'hc));
        vecs.push_back(mk(0,0,0,0,0,       1,R+'h110,R+'h306,1,1,R+'h200,  0,0,R+'h204));
        vecs.push_back(mk(0,0,0,1,R+'h10,  0,0,0,0,            1,R+'h200,  0,0,R+'h204));
        vecs.push_back(mk(0,1,1,1,R+'h110, 0,0,0,0,            1,R+'h10,   0,0,R+'h14));
        vecs.push_back(mk(0,1,1,0,0,       1,R+'h110,R+'h700,0,1,R+'h110,  1,1,R+'h304));
        vecs.push_back(mk(0,0,0,1,R+'h110, 0,0,0,0,            1,R+'h304,  0,0,R+'h308));
        vecs.push_back(mk(0,0,1,0,0,       1,R+'h10,R+'h40,1,  1,R+'h110,  1,1,R+'h304));
        vecs.push_back(mk(0,0,1,0,0,       1,R+'h110,R+'h500,1,1,R+'h110,  0,0,R+'h114));
        vecs.push_back(mk(0,1,1,0,0,       0,0,0,0,            1,R+'h110,  1,1,R+'h500));
        vecs.push_back(mk(0,0,0,1,32'hfffffffc,0,0,0,0,        1,R+'h500,  0,0,R+'h504));
        vecs.push_back(mk(0,1,1,0,0,       0,0,0,0,            1,32'hfffffffc,0,0,32'h0));
        vecs.push_back(mk(1,1,0,0,0,       1,R+'h20,R+'h80,1,  1,32'h0,    0,0,32'h4));
        vecs.push_back(mk(0,1,0,0,0,       0,0,0,0,            0,R,        0,0,R+4));
        vecs.push_back(mk(0,1,1,1,R+'h110, 0,0,0,0,            1,R,        0,0,R+4));
        vecs.push_back(mk(0,0,1,1,R+'h20,  0,0,0,0,            1,R+'h110,  0,0,R+'h114));
        vecs.push_back(mk(0,1,1,0,0,       0,0,0,0,            1,R+'h20,   0,0,R+'h24));

        rst = 1'b1; fetch_ready = 1'b0; pred_taken = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i], i);
            #1;
            compare();
        end

        // Wrap sequence: a long straight-line run stays on pc+4.
        @(negedge clk);
        rst = 1'b0; fetch_ready = 1'b1; pred_taken = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hfffffff0;
        upd_valid = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk32("wrap_pc", 100 + k, pc, 32'hfffffff0 + 32'(4 * k));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
